phase_ctrl: RTL and testbench
=============================

PHASE_CTRL -- requirements
Module: phase_ctrl

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Port: clock  input  1  sole clock, all state updates on rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 Port: run  input  1  start request, sampled only in IDLE.
REQ-005 Port: halt  input  1  stop after current instruction, sampled in WB.
REQ-006 Port: mem_ready  input  1  memory handshake completion for current mem_req.
REQ-007 Port: is_mem  input  1  current instruction needs MEM phase, sampled in EXEC.
REQ-008 Port: branch_taken  input  1  redirect PC, sampled in WB.
REQ-009 Port: branch_target  input  32  redirect address, sampled in WB.
REQ-010 Port: pc  output  32  current instruction address, registered.
REQ-011 Port: tick  output  3  phase code: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5.
REQ-012 Port: fetch_en, decode_en, exec_en, mem_en, wb_en  output  1 each  one-hot phase enables, all 0 in IDLE.
REQ-013 Port: mem_req  output  1  high in FETCH and MEM until mem_ready seen.
REQ-014 Port: busy  output  1  high in every state except IDLE.
REQ-015 Port: instr_count  output  16  retired instruction count.
REQ-016 Port: mem_timeout  output  1  sticky memory-wait timeout flag.

Function
REQ-017 State register SHALL hold one of six states; tick SHALL equal the state code; enables and mem_req SHALL decode combinationally from state.
REQ-018 IDLE: run=1 -> FETCH next cycle, else stay; run in any other state SHALL be ignored.
REQ-019 FETCH and MEM: stay while mem_ready=0; advance on first edge with mem_ready=1 (FETCH->DECODE, MEM->WB).
REQ-020 DECODE SHALL always advance to EXEC after one cycle.
REQ-021 EXEC SHALL advance to MEM if is_mem=1, else to WB.
REQ-022 Zero-wait latency: 4 cycles FETCH-to-WB-exit without memory phase, 5 with.
REQ-023 WB exit: pc <= branch_taken ? {branch_target[31:2],2'b00} : pc+4, modulo 2^32 (32'hFFFF_FFFC+4 wraps to 0).
REQ-024 WB exit: instr_count increments by 1, wraps 16'hFFFF -> 0.
REQ-025 WB exit: halt=1 -> IDLE, else FETCH; halt with branch_taken SHALL apply branch target then enter IDLE.
REQ-026 pc and instr_count SHALL change only on WB exit (or reset).

Reset
REQ-027 reset=0 SHALL immediately force state IDLE, pc=RESET_PC, instr_count=0, mem_timeout=0, wait counter=0, independent of clock.
REQ-028 Hence all enables, mem_req and busy SHALL drop immediately, including mid-handshake.
REQ-029 After reset release, block SHALL stay in IDLE until run=1 sampled.

Configuration
REQ-030 Macro PHASE_CTRL_TIMEOUT_EN defined: 4-bit wait counter SHALL count cycles with mem_req=1 and mem_ready=0, clearing when mem_ready=1 or state changes.
REQ-031 With macro: on 16th consecutive waiting cycle, state SHALL go to IDLE, mem_timeout SHALL set, pc and instr_count SHALL be unchanged; mem_timeout SHALL clear when run=1 is accepted in IDLE.
REQ-032 Macro undefined: waits SHALL be unbounded, mem_timeout tied 0, no counter logic.

Verification
REQ-033 Reset then run=1 pulse, mem_ready=1 always, is_mem=0, halt=0 -> tick 1,2,3,5,1..., pc 0,4,8 every 4 cycles, instr_count +1 each.
REQ-034 is_mem=1, mem_ready low 3 cycles in MEM -> tick stays 4 for 4 cycles total with mem_req=1, then 5; pc advances once.
REQ-035 branch_taken=1, branch_target=32'h0000_1003 with halt=1 in WB -> pc=32'h0000_1000, tick=0, busy=0, instr_count +1.
REQ-036 RESET_PC=32'hFFFF_FFFC, one instruction -> pc wraps to 32'h0000_0000.
REQ-037 reset=0 asserted mid-FETCH with mem_req=1 -> mem_req, busy, fetch_en 0 before next clock edge; pc=RESET_PC.
REQ-038 PHASE_CTRL_TIMEOUT_EN defined, mem_ready held 0 in FETCH -> after 16 wait cycles tick=0, mem_timeout=1, pc unchanged; next run clears flag.

Source files
------------

// File: rtl/phase_ctrl.sv
// Six-phase instruction sequencer: IDLE/FETCH/DECODE/EXEC/MEM/WB.
// Define PHASE_CTRL_TIMEOUT_EN to bound memory waits at 16 cycles.
module phase_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        run,
  input  logic        halt,
  input  logic        mem_ready,
  input  logic        is_mem,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] pc,
  output logic [2:0]  tick,
  output logic        fetch_en,
  output logic        decode_en,
  output logic        exec_en,
  output logic        mem_en,
  output logic        wb_en,
  output logic        mem_req,
  output logic        busy,
  output logic [15:0] instr_count,
  output logic        mem_timeout
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [15:0] cnt_q, cnt_d;
  logic        expire;

  assign tick        = state_q;
  assign fetch_en    = (state_q == S_FETCH);
  assign decode_en   = (state_q == S_DECODE);
  assign exec_en     = (state_q == S_EXEC);
  assign mem_en      = (state_q == S_MEM);
  assign wb_en       = (state_q == S_WB);
  assign mem_req     = fetch_en | mem_en;
  assign busy        = (state_q != S_IDLE);
  assign pc          = pc_q;
  assign instr_count = cnt_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE:   if (run) state_d = S_FETCH;
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: state_d = S_EXEC;
      S_EXEC:   state_d = is_mem ? S_MEM : S_WB;
      S_MEM:    if (mem_ready) state_d = S_WB;
      S_WB: begin
        pc_d    = branch_taken ?
                  {branch_target[31:2], 2'b00} :
                  pc_q + 32'd4;
        cnt_d   = cnt_q + 16'd1;
        state_d = halt ? S_IDLE : S_FETCH;
      end
      default:  state_d = S_IDLE;
    endcase
    // An expired wait abandons the instruction without retiring it
    if (expire) state_d = S_IDLE;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef PHASE_CTRL_TIMEOUT_EN
  logic [3:0] wait_q, wait_d;
  logic       to_q, to_d;
  logic       waiting;

  assign waiting     = mem_req & ~mem_ready;
  assign expire      = waiting & (wait_q == 4'hF);
  assign mem_timeout = to_q;

  always_comb begin
    wait_d = '0;
    to_d   = to_q;
    if (waiting && !expire) wait_d = wait_q + 4'd1;
    if (expire) to_d = 1'b1;
    else if (state_q == S_IDLE && run) to_d = 1'b0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wait_q <= '0;
      to_q   <= 1'b0;
    end else begin
      wait_q <= wait_d;
      to_q   <= to_d;
    end
  end
`else
  assign expire      = 1'b0;
  assign mem_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_phase_ctrl.sv
// Randomized bench for phase_ctrl: per-instruction phase plans
// are expanded into expected tick sequences and retirement effects.
module tb_phase_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        run = 1'b0;
  logic        halt = 1'b0;
  logic        mem_ready = 1'b0;
  logic        is_mem = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;

  logic [31:0] pc, pc2;
  logic [2:0]  tick, tick2;
  logic        fetch_en, decode_en, exec_en, mem_en, wb_en;
  logic        fetch_en2, decode_en2, exec_en2, mem_en2, wb_en2;
  logic        mem_req, busy, mem_timeout;
  logic        mem_req2, busy2, mem_timeout2;
  logic [15:0] instr_count, instr_count2;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] pc_m;
  logic [15:0] cnt_m;

  always #5 clock = ~clock;

  phase_ctrl dut (
    .clock(clock), .reset(reset), .run(run), .halt(halt),
    .mem_ready(mem_ready), .is_mem(is_mem),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .pc(pc), .tick(tick),
    .fetch_en(fetch_en), .decode_en(decode_en),
    .exec_en(exec_en), .mem_en(mem_en), .wb_en(wb_en),
    .mem_req(mem_req), .busy(busy),
    .instr_count(instr_count), .mem_timeout(mem_timeout)
  );

  phase_ctrl #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clock(clock), .reset(reset), .run(run), .halt(halt),
    .mem_ready(mem_ready), .is_mem(is_mem),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .pc(pc2), .tick(tick2),
    .fetch_en(fetch_en2), .decode_en(decode_en2),
    .exec_en(exec_en2), .mem_en(mem_en2), .wb_en(wb_en2),
    .mem_req(mem_req2), .busy(busy2),
    .instr_count(instr_count2), .mem_timeout(mem_timeout2)
  );

  task automatic start_run();
    run = 1'b1;
    mem_ready = 1'b0;
    @(negedge clock);
    run = 1'b0;
    checks++;
    if (tick !== 3'd1) begin
      errors++;
      $display("FAIL start_tick: got %0d want 1", tick);
    end
  endtask

  // Call at a negedge with the DUT in FETCH; returns one negedge after WB.
  task automatic run_instr(input int fw, input bit im, input int mw,
                           input bit br, input logic [31:0] tgt,
                           input bit hl);
    int q[$];
    int t;
    logic [4:0] en;
    for (int k = 0; k <= fw; k++) q.push_back(1);
    q.push_back(2);
    q.push_back(3);
    if (im) for (int k = 0; k <= mw; k++) q.push_back(4);
    q.push_back(5);
    for (int i = 0; i < q.size(); i++) begin
      if (i > 0) @(negedge clock);
      t = q[i];
      en = 5'b00001 << (t - 1);
      checks++;
      if (tick !== 3'(t)) begin
        errors++;
        $display("FAIL tick[%0d]: got %0d want %0d", i, tick, t);
      end
      checks++;
      if ({wb_en, mem_en, exec_en, decode_en, fetch_en} !== en) begin
        errors++;
        $display("FAIL enables[%0d]: got %b want %b", i,
                 {wb_en, mem_en, exec_en, decode_en, fetch_en}, en);
      end
      checks++;
      if (mem_req !== (t == 1 || t == 4) || busy !== 1'b1) begin
        errors++;
        $display("FAIL req_busy[%0d]: got %b%b want %b1", i,
                 mem_req, busy, (t == 1 || t == 4));
      end
      checks++;
      if (pc !== pc_m || instr_count !== cnt_m) begin
        errors++;
        $display("FAIL hold[%0d]: pc %h cnt %0d want %h %0d", i,
                 pc, instr_count, pc_m, cnt_m);
      end
      run = 1'($urandom);
      if (i + 1 < q.size() && q[i+1] == t) mem_ready = 1'b0;
      else if (t == 1 || t == 4) mem_ready = 1'b1;
      else mem_ready = 1'($urandom);
      is_mem        = (t == 3) ? im : 1'($urandom);
      halt          = (t == 5) ? hl : 1'($urandom);
      branch_taken  = (t == 5) ? br : 1'($urandom);
      branch_target = (t == 5) ? tgt : $urandom;
    end
    @(negedge clock);
    pc_m  = br ? {tgt[31:2], 2'b00} : pc_m + 32'd4;
    cnt_m = cnt_m + 16'd1;
    checks++;
    if (pc !== pc_m) begin
      errors++;
      $display("FAIL retire_pc: got %h want %h", pc, pc_m);
    end
    checks++;
    if (instr_count !== cnt_m) begin
      errors++;
      $display("FAIL retire_cnt: got %0d want %0d", instr_count, cnt_m);
    end
    checks++;
    if (tick !== (hl ? 3'd0 : 3'd1)) begin
      errors++;
      $display("FAIL after_wb: got %0d want %0d", tick, hl ? 0 : 1);
    end
    if (hl) run = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    run = 1'b0;
    repeat (2) @(negedge clock);
    pc_m  = '0;
    cnt_m = '0;
    checks++;
    if (tick !== 3'd0 || busy !== 1'b0 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: tick %0d busy %b req %b want 0 0 0",
               tick, busy, mem_req);
    end
    checks++;
    if (pc !== 32'h0 || instr_count !== 16'h0 || mem_timeout !== 1'b0) begin
      errors++;
      $display("FAIL reset_regs: pc %h cnt %0d to %b want 0 0 0",
               pc, instr_count, mem_timeout);
    end
    checks++;
    if (pc2 !== 32'hFFFF_FFFC) begin
      errors++;
      $display("FAIL reset_pc_param: got %h want fffffffc", pc2);
    end
    reset = 1'b1;
    repeat (3) @(negedge clock);
    checks++;
    if (tick !== 3'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_wait: tick %0d busy %b want 0 0", tick, busy);
    end
  endtask

  task automatic test_basic();
    start_run();
    for (int n = 0; n < 3; n++) run_instr(0, 0, 0, 0, '0, 0);
    run_instr(0, 0, 0, 0, '0, 1);
  endtask

  task automatic test_mem_wait();
    start_run();
    run_instr(0, 1, 3, 0, '0, 0);
    run_instr(2, 1, 0, 0, '0, 1);
  endtask

  task automatic test_branch_halt();
    start_run();
    run_instr(0, 0, 0, 1, 32'h0000_1003, 1);
    checks++;
    if (pc !== 32'h0000_1000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL branch_halt: pc %h busy %b want 00001000 0", pc, busy);
    end
  endtask

  task automatic test_random();
    bit hl;
    start_run();
    for (int n = 0; n < 30; n++) begin
      hl = ($urandom_range(0, 4) == 0);
      run_instr($urandom_range(0, 4), 1'($urandom),
                $urandom_range(0, 4), 1'($urandom), $urandom, hl);
      if (hl) begin
        repeat ($urandom_range(0, 2)) @(negedge clock);
        start_run();
      end
    end
    run_instr(0, 0, 0, 0, '0, 1);
  endtask

  task automatic test_wrap();
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    pc_m  = '0;
    cnt_m = '0;
    @(negedge clock);
    start_run();
    run_instr(1, 0, 0, 0, '0, 1);
    checks++;
    if (pc2 !== 32'h0 || instr_count2 !== 16'd1) begin
      errors++;
      $display("FAIL pc_wrap: pc %h cnt %0d want 00000000 1",
               pc2, instr_count2);
    end
  endtask

  task automatic test_async_reset();
    start_run();
    checks++;
    if (mem_req !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_req: got %b want 1", mem_req);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0 || busy !== 1'b0 || fetch_en !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: req %b busy %b fetch %b want 0 0 0",
               mem_req, busy, fetch_en);
    end
    checks++;
    if (pc !== 32'h0 || tick !== 3'd0 || instr_count !== 16'h0) begin
      errors++;
      $display("FAIL async_reset_regs: pc %h tick %0d cnt %0d want 0 0 0",
               pc, tick, instr_count);
    end
    @(negedge clock);
    reset = 1'b1;
    pc_m  = '0;
    cnt_m = '0;
    repeat (2) @(negedge clock);
    checks++;
    if (tick !== 3'd0) begin
      errors++;
      $display("FAIL post_reset_idle: got %0d want 0", tick);
    end
  endtask

  task automatic test_timeout();
`ifdef PHASE_CTRL_TIMEOUT_EN
    start_run();
    repeat (15) @(negedge clock);
    checks++;
    if (tick !== 3'd1) begin
      errors++;
      $display("FAIL wait15: got %0d want 1", tick);
    end
    @(negedge clock);
    checks++;
    if (tick !== 3'd0 || mem_timeout !== 1'b1) begin
      errors++;
      $display("FAIL timeout: tick %0d flag %b want 0 1", tick, mem_timeout);
    end
    checks++;
    if (pc !== pc_m || instr_count !== cnt_m) begin
      errors++;
      $display("FAIL timeout_regs: pc %h cnt %0d want %h %0d",
               pc, instr_count, pc_m, cnt_m);
    end
    start_run();
    checks++;
    if (mem_timeout !== 1'b0) begin
      errors++;
      $display("FAIL timeout_clear: got %b want 0", mem_timeout);
    end
    run_instr(0, 1, 15, 0, '0, 1);
`else
    start_run();
    run_instr(20, 1, 18, 0, '0, 1);
    checks++;
    if (mem_timeout !== 1'b0) begin
      errors++;
      $display("FAIL no_timeout: got %b want 0", mem_timeout);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_mem_wait();
    test_branch_halt();
    test_random();
    test_wrap();
    test_async_reset();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
